// File: rtl/onehot_scan_pkg.sv
// Shared types for the one-hot scan decoder: sequencer state encoding and a state helper.
package onehot_scan_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SCAN   = 2'd1,
    DIRECT = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // Select lines are driven in every state except OFF.
  function automatic logic is_active(input state_t s);
    return s != OFF;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational W-to-2**W one-hot decoder with an enable that blanks all lines.
module dec_onehot #(
  parameter int W = 3
) (
  input  logic [W-1:0]    i,
  input  logic            en,
  output logic [2**W-1:0] o
);

  for (genvar gi = 0; gi < 2**W; gi++) begin : g_line
    assign o[gi] = en && (i == W'(gi));
  end

endmodule

// File: rtl/onehot_scan_dec.sv
// Registered one-hot decoder with an auto-scan / direct-load address sequencer.
// Optional macro ONEHOT_SCAN_BLANK_EN blanks o for one cycle after every sel change.
module onehot_scan_dec
  import onehot_scan_pkg::*;
#(
  parameter int W   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [W-1:0]    addr,
  input  logic            load,
  output logic            ready,
  output logic [W-1:0]    sel,
  output logic            wrap,
  output logic [2**W-1:0] o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    sel_reg, sel_next;
  logic            wrap_reg, wrap_next;
  logic            blank;
  logic            dec_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= OFF;
      cnt_reg   <= '0;
      sel_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Next-state logic; a disabled block always parks in OFF with sel held.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    wrap_next  = 1'b0;
    if (!en) begin
      state_next = OFF;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        OFF: begin
          state_next = mode ? DIRECT : SCAN;
          cnt_next   = '0;
        end
        SCAN: begin
          if (mode) begin
            state_next = DIRECT;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_MAX) begin
            cnt_next  = '0;
            sel_next  = sel_reg + W'(1);
            wrap_next = (sel_reg == {W{1'b1}});
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        DIRECT: begin
          if (!mode) begin
            state_next = SCAN;
            cnt_next   = '0;
          end else if (load) begin
            state_next = SETTLE;
            sel_next   = addr;
            cnt_next   = '0;
          end
        end
        SETTLE: begin
          if (cnt_reg == CNT_MAX) begin
            state_next = DIRECT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef ONEHOT_SCAN_BLANK_EN
  logic blank_reg, blank_next;

  // Any scan step or accepted load (even of the same address) counts as a sel change.
  assign blank_next = en && (
      (state_reg == SCAN   && !mode && cnt_reg == CNT_MAX) ||
      (state_reg == DIRECT &&  mode && load));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_reg <= 1'b0;
    else     blank_reg <= blank_next;
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

  // Outputs depend only on registered state.
  always_comb begin
    ready  = (state_reg == DIRECT);
    dec_en = is_active(state_reg) && !blank;
  end

  assign sel  = sel_reg;
  assign wrap = wrap_reg;

  dec_onehot #(.W(W)) u_dec (
    .i  (sel_reg),
    .en (dec_en),
    .o  (o)
  );

endmodule

// File: doc/onehot_scan_dec.md
# onehot_scan_dec

Parametrised, registered one-hot decoder with a built-in address sequencer. It drives 2**W select lines, one at a time, either by auto-scanning with a programmable step period (display digit multiplexing, round-robin channel enable) or by accepting explicit addresses over a ready/load handshake. It replaces the fixed-width combinational decoders wherever select lines must be sequenced or held stable for a settle period.

## Interface
Parameters:
- W, default 3: address width; output has N = 2**W lines; W >= 1.
- DIV, default 4: cycles per scan step and settle length after a load; DIV >= 1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; 0 blanks all outputs.
- mode  in  1  0 = scan, 1 = direct.
- addr  in  W  direct-mode address.
- load  in  1  direct-mode load request, accepted only when ready=1.
- ready  out  1  direct-mode handshake; 1 = load will be accepted this cycle.
- sel  out  W  current registered address.
- wrap  out  1  one-cycle pulse when a scan step takes sel from N-1 to 0.
- o  out  N  one-hot select, o[sel]=1 when active, else all zero.

## Operation
- States: OFF, SCAN, DIRECT, SETTLE; internal counter cnt in 0..DIV-1.
- en=0 in any state: next state OFF, cnt<=0, sel held. This has highest priority after rst.
- OFF: o=0, ready=0. If en=1, go to SCAN when mode=0, else DIRECT; cnt<=0.
- SCAN: cnt increments each cycle. When cnt==DIV-1: cnt<=0, sel<=sel+1 modulo N, and wrap<=1 iff sel==N-1. If mode=1: go to DIRECT, cnt<=0, no step that cycle.
- DIRECT: ready=1. mode=0 is checked first: go to SCAN, cnt<=0, load ignored. Otherwise load=1 sets sel<=addr, cnt<=0, and goes to SETTLE.
- SETTLE: ready=0, load ignored, mode ignored. cnt increments. At cnt==DIV-1: cnt<=0, return to DIRECT.
- o = decode(sel) in SCAN, DIRECT and SETTLE; o = 0 in OFF. o depends only on registered state, with no input-to-output combinational path.
- Reloading the same address still enters SETTLE.

## Timing
- Reset values: state OFF, sel=0, cnt=0, wrap=0, ready=0, o=0. These take effect immediately on rst assertion, independent of clk.
- Reset mid-operation discards any step or settle in progress. No partial state survives.
- Scan: each sel value is held exactly DIV cycles. wrap is high during the first cycle of sel==0 in each new round.
- Load accepted at edge t: sel/o show addr from t+1. ready is 0 for cycles t+1..t+DIV and returns to 1 at t+DIV+1.
- en deasserted at edge t: o=0 from t+1.
- After re-enable, scan resumes from the held sel with a full DIV-cycle hold.
- DIV=1: sel steps every SCAN cycle, and SETTLE lasts one cycle.

## Configuration
- ONEHOT_SCAN_BLANK_EN defined: o is forced to 0 for the first cycle after every sel change (scan step or load), for anti-ghosting. sel, wrap, ready and cnt timing are unchanged.
- With the blank active and DIV=1 in scan, o is always 0. This combination is legal but useless.
- Undefined: o follows sel with no blank cycle.

## Structure
- Package onehot_scan_pkg holds the state enum typedef (OFF, SCAN, DIRECT, SETTLE).
- Sub-module dec_onehot #(W): purely combinational, inputs i[W-1:0] and en, output o[2**W-1:0].
  - o = 0 when en=0.
  - Used once, with en driven by the state-not-OFF term and the blank term.

## Test plan
- Reset: assert rst mid-scan between clk edges → o=0, sel=0, ready=0, wrap=0 immediately; cnt is cleared.
- Scan with W=3, DIV=4, en=1, mode=0 from reset → o steps 0000_0001, 0000_0010, … 1000_0000, 0000_0001, each held 4 cycles. wrap pulses once every 32 cycles, aligned with the return to 0000_0001.
- Direct with W=3, DIV=4: load addr=5 while ready=1 → o=0010_0000 next cycle, ready low 4 cycles. A load of addr=2 during SETTLE is ignored, with o still 0010_0000.
- Enable drop: en=0 while sel=6 → o=0 next cycle. Re-enable with mode=0 → o=0100_0000 held 4 cycles, then 1000_0000.
- Blank macro defined, W=2, DIV=3, scan → o shows 0000, 0001, 0001, 0000, 0010, 0010, … (one zero cycle per step). Undefined → no zero cycles.
- W=2, DIV=1, scan → o rotates every cycle, wrap high every 4th cycle. Switching mode to 1 mid-rotation freezes o with ready=1 the next cycle.
